// File: rtl/matrix_mem_reader_if.sv
//------------------------------------------------------------------------------
// Module      : matrix_mem_reader_if
// Description : Control, BRAM and matrix-result bundle for matrix_mem_reader.
//               The transpose line is present only when
//               MATRIX_MEM_READER_TRANSPOSE_EN is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface matrix_mem_reader_if #(
  parameter int N  = 32,
  parameter int P  = 4,
  parameter int AW = 4
);
  logic                 start;
  logic [AW-1:0]        mem_addr;
  logic                 mem_read;
  logic                 mem_write;
  logic [N-1:0]         mem_data;
  logic [P*P*N-1:0]     matrix_out;
  logic                 busy;
  logic                 done;
  logic                 valid;
`ifdef MATRIX_MEM_READER_TRANSPOSE_EN
  logic                 transpose;
`endif

  // master: the reader, driving the BRAM port and the result bus
  modport master (
`ifdef MATRIX_MEM_READER_TRANSPOSE_EN
    input  transpose,
`endif
    input  start, mem_data,
    output mem_addr, mem_read, mem_write, matrix_out, busy, done, valid
  );

  // slave: the requester and BRAM side
  modport slave (
`ifdef MATRIX_MEM_READER_TRANSPOSE_EN
    output transpose,
`endif
    output start, mem_data,
    input  mem_addr, mem_read, mem_write, matrix_out, busy, done, valid
  );
endinterface

`default_nettype wire

// File: rtl/matrix_mem_reader.sv
//------------------------------------------------------------------------------
// Module      : matrix_mem_reader
// Description : Streams one PxP matrix out of a 1-cycle-latency BRAM and
//               publishes it atomically as a flat P*P*N bus.
//               Optional macro MATRIX_MEM_READER_TRANSPOSE_EN adds a transpose
//               input that stores the matrix as M^T.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module matrix_mem_reader #(
  parameter int N  = 32,
  parameter int P  = 4,
  parameter int AW = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  matrix_mem_reader_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_LAST = 2'd2
  } state_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(P*P-1);

  state_e               state_q;
  logic [AW-1:0]        rd_cnt_q;
  logic                 pend_vld_q;
  logic [AW-1:0]        pend_idx_q;
  logic [P*P*N-1:0]     shadow_q;
  logic [P*P*N-1:0]     shadow_d;
  logic [P*P*N-1:0]     matrix_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 valid_q;
  logic [AW-1:0]        slot_d;
  logic                 accept_d;

`ifdef MATRIX_MEM_READER_TRANSPOSE_EN
  logic                 trans_q;
  logic [AW-1:0]        row_q;
  logic [AW-1:0]        col_q;

  assign slot_d = trans_q ? AW'(col_q * P + row_q) : rd_cnt_q;
`else
  assign slot_d = rd_cnt_q;
`endif

  // The completion edge is also a legal start edge, giving P*P+1 cycle throughput
  assign accept_d = bus.start && ((state_q == S_IDLE) || (state_q == S_LAST));

  always_comb begin
    shadow_d = shadow_q;
    if (pend_vld_q) begin
      shadow_d[pend_idx_q*N +: N] = bus.mem_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rd_cnt_q   <= '0;
      pend_vld_q <= 1'b0;
      pend_idx_q <= '0;
      shadow_q   <= '0;
      matrix_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
`ifdef MATRIX_MEM_READER_TRANSPOSE_EN
      trans_q    <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
`endif
    end else begin
      done_q     <= 1'b0;
      pend_vld_q <= 1'b0;
      shadow_q   <= shadow_d;
      case (state_q)
        S_IDLE: begin
        end
        S_READ: begin
          pend_vld_q <= 1'b1;
          pend_idx_q <= slot_d;
          rd_cnt_q   <= rd_cnt_q + 1'b1;
`ifdef MATRIX_MEM_READER_TRANSPOSE_EN
          if (col_q == AW'(P-1)) begin
            col_q <= '0;
            row_q <= row_q + 1'b1;
          end else begin
            col_q <= col_q + 1'b1;
          end
`endif
          if (rd_cnt_q == LAST_IDX) begin
            state_q <= S_LAST;
          end
        end
        S_LAST: begin
          state_q  <= S_IDLE;
          matrix_q <= shadow_d;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          valid_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
      if (accept_d) begin
        state_q  <= S_READ;
        rd_cnt_q <= '0;
        busy_q   <= 1'b1;
`ifdef MATRIX_MEM_READER_TRANSPOSE_EN
        trans_q  <= bus.transpose;
        row_q    <= '0;
        col_q    <= '0;
`endif
      end
    end
  end

  assign bus.mem_read   = (state_q == S_READ);
  assign bus.mem_addr   = (state_q == S_READ) ? rd_cnt_q : '0;
  assign bus.mem_write  = 1'b0;
  assign bus.matrix_out = matrix_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.valid      = valid_q;

endmodule

`default_nettype wire
